method_call_arbiter: RTL

Shares one Synthesijer-generated method port (`<method>_req` / `<method>_busy` / `<method>_return` plus argument inputs) among several requesters. The block arbitrates round-robin and latches the winner's arguments. It issues a single-cycle request, follows the method's busy handshake to completion, and returns the result to the winning client. It sits between client logic or bench drivers and a generated module such as a `Test001`-style core. It also includes a watchdog so that a hung method cannot stall the system.

---
 rtl/method_call_arbiter_if.sv | 12 +
 rtl/method_call_arbiter.sv | 117 +++++++++++
 2 files changed

// File: rtl/method_call_arbiter_if.sv
// method_call_arbiter_if: the shared method call port (request, arguments, busy, result)
interface method_call_arbiter_if #(
  parameter int ARG_W = 64,
  parameter int RET_W = 32
);
  logic             m_req;
  logic [ARG_W-1:0] m_arg;
  logic             m_busy;
  logic [RET_W-1:0] m_return;
  modport master (output m_req, m_arg, input m_busy, m_return);
  modport slave (input m_req, m_arg, output m_busy, m_return);
endinterface

// File: rtl/method_call_arbiter.sv
// method_call_arbiter: round-robin sharing of one method call port, with busy handshake and watchdog
module method_call_arbiter #(
  parameter int N_CLIENTS = 4,
  parameter int ARG_W = 64,
  parameter int RET_W = 32,
  parameter int TIMEOUT = 1024,
  localparam int IW = $clog2(N_CLIENTS),
  localparam int WW = $clog2(TIMEOUT)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_CLIENTS-1:0]       cli_req,
  input  logic [N_CLIENTS*ARG_W-1:0] cli_arg,
  output logic [N_CLIENTS-1:0]       cli_ack,
  output logic [N_CLIENTS-1:0]       cli_done,
  output logic [RET_W-1:0]           cli_return,
  output logic                       cli_error,
  output logic [IW-1:0]              grant_id,
  output logic                       idle,
  method_call_arbiter_if.master      m
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, COMPLETE} state_t;
  localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT - 1);
  state_t state, state_d;
  logic [WW-1:0] wd, wd_d;
  logic [IW-1:0] last, last_d, gid_d, pick, idx;
  logic found, err_d, req_d;
  logic [N_CLIENTS-1:0] ack_d, done_d;
  logic [RET_W-1:0] ret_d;
  logic [ARG_W-1:0] arg_d;
  // first requester after the previous winner, wrapping around
  always_comb begin
    found = 1'b0;
    pick = '0;
    idx = '0;
    for (int k = 1; k <= N_CLIENTS; k++) begin
      idx = IW'((int'(last) + k) % N_CLIENTS);
      if (!found && cli_req[idx]) begin
        found = 1'b1;
        pick = idx;
      end
    end
  end
  always_comb begin
    state_d = state;
    wd_d = wd;
    last_d = last;
    gid_d = grant_id;
    arg_d = m.m_arg;
    ret_d = cli_return;
    ack_d = '0;
    done_d = '0;
    err_d = 1'b0;
    req_d = 1'b0;
    case (state)
      IDLE: if (found && !m.m_busy) begin
        state_d = ISSUE;
        gid_d = pick;
        arg_d = cli_arg[pick*ARG_W +: ARG_W];
        ack_d[pick] = 1'b1;
        req_d = 1'b1;
      end
      ISSUE: begin
        state_d = WAIT_BUSY;
        wd_d = '0;
      end
      WAIT_BUSY, WAIT_DONE: begin
        wd_d = (wd == WD_MAX) ? wd : wd + 1'b1;
        if (state == WAIT_BUSY && m.m_busy) begin
          state_d = WAIT_DONE;
          wd_d = '0;
        end else if (state == WAIT_DONE && !m.m_busy) begin
          state_d = COMPLETE;
          done_d[grant_id] = 1'b1;
          ret_d = m.m_return;
        end else if (wd == WD_MAX) begin
          state_d = COMPLETE;
          done_d[grant_id] = 1'b1;
          err_d = 1'b1;
          ret_d = '0;
        end
      end
      COMPLETE: begin
        state_d = IDLE;
        last_d = grant_id;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      wd <= '0;
      last <= IW'(N_CLIENTS - 1);
      grant_id <= '0;
      m.m_arg <= '0;
      m.m_req <= 1'b0;
      cli_ack <= '0;
      cli_done <= '0;
      cli_return <= '0;
      cli_error <= 1'b0;
      idle <= 1'b1;
    end else begin
      state <= state_d;
      wd <= wd_d;
      last <= last_d;
      grant_id <= gid_d;
      m.m_arg <= arg_d;
      m.m_req <= req_d;
      cli_ack <= ack_d;
      cli_done <= done_d;
      cli_return <= ret_d;
      cli_error <= err_d;
      idle <= (state_d == IDLE);
    end
  end
endmodule
